// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Byte-oriented UART transmitter with a small transmit FIFO.
//               Frames are start(0) + 8 data bits LSB first + stop(1); each
//               bit lasts CLK_DIV clk cycles. A companion bit clock UART_clk
//               is low for the first half and high for the second half of
//               every bit, so a receiver samples UART_tx on its rising edge.
//
// Parameters  : CLK_DIV    - clk cycles per UART bit (even, >= 2)
//               FIFO_DEPTH - transmit FIFO entries (power of two, >= 2)
//
// Ports       : clk      in   single clock, rising edge
//               rst      in   synchronous active-high reset
//               wr_data  in   [7:0] byte to enqueue
//               wr_en    in   enqueue strobe, taken when full=0
//               full     out  FIFO holds FIFO_DEPTH bytes
//               empty    out  FIFO holds no bytes
//               busy     out  a frame is in progress
//               UART_tx  out  serial data line, idle high
//               UART_clk out  bit clock, held low outside frames
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       UART_tx,
    output logic       UART_clk
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);

    localparam logic [CW-1:0] c_fifo_full = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] c_cnt_max   = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_cnt_half  = BW'(CLK_DIV / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [BW-1:0] cnt_q;
    logic [BW-1:0] w_cnt_inc;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          uclk_q;
    logic          w_bit_end;

    assign full   = (count_q == c_fifo_full);
    assign empty  = (count_q == '0);
    assign w_head = mem_q[rd_ptr_q];

    // A push while full is simply not a push, so a same-cycle pop cannot
    // make room for it.
    assign w_push = wr_en & ~full;

    assign w_bit_end = (cnt_q == c_cnt_max);
    assign w_cnt_inc = cnt_q + 1'b1;

    // Pop from IDLE immediately, or at the very last cycle of the stop bit
    // so the next start bit follows with no idle gap.
    assign w_pop = ~empty & ((state_q == S_IDLE) |
                             ((state_q == S_STOP) & w_bit_end));

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM. UART_tx and UART_clk are driven straight from flops; the
    // value loaded at each edge is the one for the cycle that follows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            uclk_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    uclk_q <= 1'b0;
                    cnt_q  <= '0;
                    if (w_pop) begin
                        state_q <= S_START;
                        shreg_q <= w_head;
                        tx_q    <= 1'b0;
                    end
                end

                default: begin
                    if (w_bit_end) begin
                        cnt_q  <= '0;
                        uclk_q <= 1'b0;
                        case (state_q)
                            S_START: begin
                                state_q   <= S_DATA;
                                bit_idx_q <= '0;
                                tx_q      <= shreg_q[0];
                                shreg_q   <= {1'b0, shreg_q[7:1]};
                            end
                            S_DATA: begin
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 1'b1;
                                    tx_q      <= shreg_q[0];
                                    shreg_q   <= {1'b0, shreg_q[7:1]};
                                end
                            end
                            default: begin
                                if (w_pop) begin
                                    state_q <= S_START;
                                    shreg_q <= w_head;
                                    tx_q    <= 1'b0;
                                end else begin
                                    state_q <= S_IDLE;
                                    tx_q    <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        cnt_q  <= w_cnt_inc;
                        // Second half of the bit period drives the bit clock high.
                        uclk_q <= (w_cnt_inc >= c_cnt_half);
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign UART_tx  = tx_q;
    assign UART_clk = uclk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Scoreboard bench for uart_tx_serializer (CLK_DIV=16,
//               FIFO_DEPTH=4). Stimulus pushes each byte expected on the
//               line; a receiver process decodes frames on UART_clk rising
//               edges and compares them against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       busy;
    logic       UART_tx;
    logic       UART_clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    uart_tx_serializer #(
        .CLK_DIV    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .UART_tx  (UART_tx),
        .UART_clk (UART_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts busy cycles from the current one until busy drops (bounded).
    task automatic measure_busy(input string name, input int exp_n);
        int n;
        int guard;
        n     = busy ? 1 : 0;
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
            if (busy) n++;
        end
        check(name, n, exp_n);
    endtask

    // ------------------------------------------------------------------
    // Receiver / scoreboard monitor
    // ------------------------------------------------------------------
    logic       prev_uclk = 1'b0;
    int         nbits     = 0;
    logic [9:0] frame     = '0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            nbits     = 0;
            prev_uclk = 1'b0;
        end else begin
            if (UART_clk && !prev_uclk) begin
                frame[nbits] = UART_tx;
                nbits++;
                if (nbits == 10) begin
                    nbits = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rx_unexpected: got frame %h expected no frame", frame);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (frame !== {1'b1, exp_b, 1'b0}) begin
                            failures++;
                            $display("FAIL rx_frame: got frame %h expected %h",
                                     frame, {1'b1, exp_b, 1'b0});
                        end
                    end
                end
            end
            prev_uclk = UART_clk;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;
        int bad;

        rst     = 1'b1;
        wr_en   = 1'b1;        // must be ignored while in reset
        wr_data = 8'h99;
        tick();
        tick();
        check("rst_tx",    int'(UART_tx),  1);
        check("rst_uclk",  int'(UART_clk), 0);
        check("rst_busy",  int'(busy),     0);
        check("rst_empty", int'(empty),    1);
        check("rst_full",  int'(full),     0);
        rst   = 1'b0;
        wr_en = 1'b0;
        tick();
        tick();
        check("rst_wr_ignored_empty", int'(empty), 1);
        check("rst_wr_ignored_busy",  int'(busy),  0);

        // ---- single byte 0x41: latency and frame length -------------
        wr_data = 8'h41;
        wr_en   = 1'b1;
        exp_q.push_back(8'h41);
        tick();
        wr_en = 1'b0;
        check("t1_visible_empty", int'(empty),   0);
        check("t1_no_bypass_tx",  int'(UART_tx), 1);
        tick();
        check("t1_start_tx",   int'(UART_tx), 0);
        check("t1_start_busy", int'(busy),    1);
        measure_busy("t1_busy_cycles", 160);
        check("t1_idle_tx",   int'(UART_tx),  1);
        check("t1_idle_uclk", int'(UART_clk), 0);

        // ---- "Hi\n" back to back ------------------------------------
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       wr_data = 8'h48;
                1:       wr_data = 8'h69;
                default: wr_data = 8'h0A;
            endcase
            wr_en = 1'b1;
            exp_q.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
        check("t2_busy_now", int'(busy), 1);
        // busy began one edge before the third write landed
        begin
            int n;
            int guard;
            n     = 2;
            guard = 0;
            while (busy && guard < 3000) begin
                tick();
                guard++;
                if (busy) n++;
            end
            check("t2_busy_cycles", n, 480);
        end
        check("t2_drained", exp_q.size(), 0);

        // ---- fill while busy, drops, full write at pop ---------------
        wr_data = 8'h00;
        wr_en   = 1'b1;
        exp_q.push_back(8'h00);
        tick();
        wr_en = 1'b0;
        tick();
        check("t3_start_tx", int'(UART_tx), 0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'hA1 + i);
            wr_en   = 1'b1;
            if (i < 4) exp_q.push_back(wr_data);
            tick();
            k++;
            if (i == 3) check("t3_full_after_4", int'(full), 1);
        end
        wr_en = 1'b0;
        check("t3_full_after_6", int'(full), 1);
        while (k < 159) begin
            tick();
            k++;
        end
        check("t3_full_before_pop", int'(full), 1);
        wr_data = 8'hEE;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        check("t3_full_after_pop", int'(full),    0);
        check("t3_empty_after_pop", int'(empty),  0);
        check("t3_b2b_start_tx",   int'(UART_tx), 0);
        measure_busy("t3_busy_cycles", 640);
        check("t3_drained", exp_q.size(), 0);

        // ---- reset in the middle of a frame --------------------------
        wr_data = 8'hC3;
        wr_en   = 1'b1;
        exp_q.push_back(8'hC3);
        tick();
        wr_en = 1'b0;
        tick();
        k = 0;
        while (k < 70) begin
            wr_en = (k == 5);
            wr_data = 8'h3C;
            tick();
            k++;
        end
        wr_en = 1'b0;
        rst   = 1'b1;
        tick();
        check("t4_abort_tx",    int'(UART_tx),  1);
        check("t4_abort_uclk",  int'(UART_clk), 0);
        check("t4_abort_empty", int'(empty),    1);
        check("t4_abort_busy",  int'(busy),     0);
        exp_q.delete();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0 || UART_clk !== 1'b0 || UART_tx !== 1'b1) bad++;
        end
        check("t4_stays_idle", bad, 0);
        wr_data = 8'h55;
        wr_en   = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        wr_en = 1'b0;
        tick();
        check("t4_restart_tx", int'(UART_tx), 0);
        measure_busy("t4_busy_cycles", 160);
        check("t4_drained", exp_q.size(), 0);

        // ---- 0xFF: bit7 passes through, line idles high -------------
        wr_data = 8'hFF;
        wr_en   = 1'b1;
        exp_q.push_back(8'hFF);
        tick();
        wr_en = 1'b0;
        tick();
        check("t5_start_tx", int'(UART_tx), 0);
        measure_busy("t5_busy_cycles", 160);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (UART_tx !== 1'b1 || UART_clk !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        check("t5_idle_line", bad, 0);
        check("t5_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, meaning clk cycles per UART bit (even, >=2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_data  input  8  byte to enqueue.
REQ-006 The block SHALL have port wr_en  input  1  enqueue strobe; a byte is accepted when wr_en=1 and full=0.
REQ-007 The block SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 The block SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 The block SHALL have port busy  output  1  a frame is in progress (FSM not IDLE).
REQ-010 The block SHALL have port UART_tx  output  1  serial data line, idle high.
REQ-011 The block SHALL have port UART_clk  output  1  bit clock; a receiver samples UART_tx on its rising edge.

Function
REQ-012 The frame SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; 10 bits, 10*CLK_DIV clk cycles.
REQ-013 Each bit SHALL hold UART_tx constant for CLK_DIV cycles; UART_clk SHALL be 0 for the first CLK_DIV/2 cycles and 1 for the last CLK_DIV/2 cycles of that bit.
REQ-014 UART_clk SHALL toggle only inside a frame: exactly 10 rising edges per frame, held 0 in IDLE.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; transitions IDLE->START, START->DATA after one bit, DATA->STOP after 8 bits (3-bit bit index 0..7), STOP->IDLE or STOP->START.
REQ-016 In IDLE with empty=0, the block SHALL pop the FIFO head into the shift register and enter START on the next cycle.
REQ-017 In the last cycle of STOP with empty=0, the block SHALL pop and enter START on the next cycle (back-to-back frames, no idle gap); with empty=1 it SHALL enter IDLE.
REQ-018 Latency: wr_en accepted at cycle N into an empty FIFO with the FSM in IDLE SHALL give UART_tx=0 (start bit) at cycle N+2.
REQ-019 The FIFO SHALL have no bypass path; a write into an empty FIFO is visible (empty=0) in the cycle after it is accepted.
REQ-020 A write while full=1 SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-021 A simultaneous accepted write and pop SHALL leave the FIFO count unchanged, and byte order SHALL be preserved.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL derive from an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-023 The bit-period counter SHALL count 0..CLK_DIV-1 and wrap to 0 at each bit boundary.
REQ-024 busy SHALL be 1 from the first START cycle through the last STOP cycle, and 0 only in IDLE.
REQ-025 Data bytes with bit7=1 SHALL be transmitted unmodified; no filtering is done in this block.

Reset
REQ-026 On rst=1 at a clk edge: UART_tx=1, UART_clk=0, busy=0, empty=1, full=0, FSM=IDLE, and all counters and FIFO pointers 0.
REQ-027 Reset during a frame SHALL abort it at once: UART_tx=1 and UART_clk=0 on the next cycle, FIFO contents discarded, no further UART_clk edges.
REQ-028 wr_en asserted while rst=1 SHALL be ignored.

Verification
REQ-029 CLK_DIV=16, write 0x41 once -> UART_tx falls 2 cycles later; 10 UART_clk rises; sampled bits 0,1,0,0,0,0,0,1,0,1; busy high 160 cycles.
REQ-030 Write "Hi\n" (0x48,0x69,0x0A) on consecutive cycles -> three frames back-to-back, 480 cycles, no idle gap; a bench receiver decodes 0x48,0x69,0x0A in order.
REQ-031 Stall the FSM, write 6 bytes with FIFO_DEPTH=4 -> full=1 after 4 accepts; bytes 5 and 6 dropped; only the first 4 are transmitted.
REQ-032 Assert rst at cycle 70 of a frame -> UART_tx=1 and UART_clk=0 the next cycle, empty=1, busy=0; a later write of 0x55 transmits cleanly.
REQ-033 With full=1, assert wr_en in the cycle a STOP-end pop occurs -> write dropped; count goes 4->3.
REQ-034 Write 0xFF -> frame bits 0,1x8,1; line stays high after the stop bit; UART_clk stays 0 in idle.
